// File: rtl/vend_pkg.sv
// Shared types for the vending machine payout path.
// Coin encodings, denomination values and payout FSM states.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_1    = 2'b01,
        COIN_5    = 2'b10,
        COIN_10   = 2'b11
    } coin_t;

    localparam int VAL_1  = 1;
    localparam int VAL_5  = 5;
    localparam int VAL_10 = 10;

    typedef enum logic [1:0] {
        CHG_IDLE,
        CHG_SELECT,
        CHG_ISSUE,
        CHG_DONE
    } chg_state_t;

    function automatic logic [3:0] coin_value(input coin_t c);
        logic [3:0] v;
        case (c)
            COIN_1:  v = 4'(VAL_1);
            COIN_5:  v = 4'(VAL_5);
            COIN_10: v = 4'(VAL_10);
            default: v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin picker for the change dispenser.
// Chooses the largest stocked coin not exceeding the remainder.
module change_coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W = 8,
    parameter int INV_W = 6
) (
    input  logic [AMT_W-1:0] rem,
    input  logic [INV_W-1:0] n10,
    input  logic [INV_W-1:0] n5,
    input  logic [INV_W-1:0] n1,
    output coin_t            choice,
    output logic             found
);

    logic fit10;
    logic fit5;
    logic fit1;

    assign fit10 = (rem >= AMT_W'(VAL_10)) && (n10 != '0);
    assign fit5  = (rem >= AMT_W'(VAL_5))  && (n5  != '0);
    assign fit1  = (rem >= AMT_W'(VAL_1))  && (n1  != '0);

    // Priority pick: largest denomination first.
    always_comb begin
        choice = COIN_NONE;
        found  = 1'b0;
        if (fit10) begin
            choice = COIN_10;
            found  = 1'b1;
        end else if (fit5) begin
            choice = COIN_5;
            found  = 1'b1;
        end else if (fit1) begin
            choice = COIN_1;
            found  = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Coin payout unit: breaks an amount into 10/5/1 coins
// from a local inventory and hands them out one per ack.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W    = 8,
    parameter int INV_W    = 6,
    parameter int INIT_N10 = 8,
    parameter int INIT_N5  = 8,
    parameter int INIT_N1  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic             coin_valid,
    output logic [1:0]       coin_type,
    input  logic             coin_ack,
    input  logic             refill_en,
    input  logic [1:0]       refill_type,
    input  logic [INV_W-1:0] refill_count,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    output logic [INV_W-1:0] inv_n10,
    output logic [INV_W-1:0] inv_n5,
    output logic [INV_W-1:0] inv_n1
);

    chg_state_t       state;
    chg_state_t       state_next;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] rem_after;
    coin_t            coin_sel;
    coin_t            pick;
    logic             found;

    function automatic logic [INV_W-1:0] sat_add(
        input logic [INV_W-1:0] a,
        input logic [INV_W-1:0] b
    );
        logic [INV_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[INV_W] ? {INV_W{1'b1}} : sum[INV_W-1:0];
    endfunction

    change_coin_select #(
        .AMT_W (AMT_W),
        .INV_W (INV_W)
    ) u_select (
        .rem    (rem),
        .n10    (inv_n10),
        .n5     (inv_n5),
        .n1     (inv_n1),
        .choice (pick),
        .found  (found)
    );

    assign rem_after  = rem - AMT_W'(coin_value(coin_sel));

    assign req_ready  = (state == CHG_IDLE);
    assign coin_valid = (state == CHG_ISSUE);
    assign done       = (state == CHG_DONE);
    assign coin_type  = coin_valid ? coin_sel : COIN_NONE;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CHG_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode for the payout sequence.
    always_comb begin
        state_next = state;
        case (state)
            CHG_IDLE: begin
                if (req_valid) begin
                    if (req_amount == '0) begin
                        state_next = CHG_DONE;
                    end else begin
                        state_next = CHG_SELECT;
                    end
                end
            end
            CHG_SELECT: begin
                if (found) begin
                    state_next = CHG_ISSUE;
                end else begin
                    state_next = CHG_DONE;
                end
            end
            CHG_ISSUE: begin
                if (coin_ack) begin
                    if (rem_after == '0) begin
                        state_next = CHG_DONE;
                    end else begin
                        state_next = CHG_SELECT;
                    end
                end
            end
            CHG_DONE: begin
                state_next = CHG_IDLE;
            end
            default: begin
                state_next = CHG_IDLE;
            end
        endcase
    end

    // Remainder, chosen coin and result flags; result is
    // registered on entry to DONE so it is visible with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem       <= '0;
            coin_sel  <= COIN_NONE;
            short     <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                CHG_IDLE: begin
                    if (req_valid) begin
                        rem       <= req_amount;
                        short     <= 1'b0;
                        remaining <= '0;
                    end
                end
                CHG_SELECT: begin
                    if (found) begin
                        coin_sel <= pick;
                    end else begin
                        short     <= (rem != '0);
                        remaining <= rem;
                    end
                end
                CHG_ISSUE: begin
                    if (coin_ack) begin
                        rem <= rem_after;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Coin inventory: refills only while idle, one coin
    // removed per acknowledged issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_n10 <= INV_W'(INIT_N10);
            inv_n5  <= INV_W'(INIT_N5);
            inv_n1  <= INV_W'(INIT_N1);
        end else if (state == CHG_IDLE) begin
            if (refill_en) begin
                case (refill_type)
                    COIN_10: inv_n10 <= sat_add(inv_n10, refill_count);
                    COIN_5:  inv_n5  <= sat_add(inv_n5, refill_count);
                    COIN_1:  inv_n1  <= sat_add(inv_n1, refill_count);
                    default: begin
                    end
                endcase
            end
        end else if (state == CHG_ISSUE && coin_ack) begin
            case (coin_sel)
                COIN_10: inv_n10 <= inv_n10 - 1'b1;
                COIN_5:  inv_n5  <= inv_n5 - 1'b1;
                COIN_1:  inv_n1  <= inv_n1 - 1'b1;
                default: begin
                end
            endcase
        end
    end

endmodule
